// File: rtl/reaction_ctrl.sv
// Reaction-time game sequencer: random LFSR-seeded wait, stimulus LED, ms reaction timer.
// Optional REACTION_BEST_EN adds a best_ms output holding the best non-timeout result since reset.
module reaction_ctrl #(
   parameter int unsigned CNT_W        = 14,
   parameter int unsigned MIN_DELAY_MS = 1000,
   parameter int unsigned DELAY_SHIFT  = 4,
   parameter int unsigned MAX_MS       = 9999
) (
   input  logic             clk,
   input  logic             res,
   input  logic             start,
   input  logic             react,
   input  logic             tick_1ms,
   input  logic [7:0]       lfsr_val,
   output logic             lfsr_stop,
   output logic             lfsr_res,
   output logic             led,
   output logic [CNT_W-1:0] time_ms,
   output logic             done,
   output logic             foul,
   output logic             timeout,
   output logic             busy
`ifdef REACTION_BEST_EN
   ,
   output logic [CNT_W-1:0] best_ms
`endif
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SEED = 3'd1,
      LOAD = 3'd2,
      WAIT = 3'd3,
      GO   = 3'd4,
      DONE = 3'd5,
      FOUL = 3'd6
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] delay, delay_nx;
   logic [CNT_W-1:0] time_nx;
   logic             timeout_nx;

   // State register
   always_ff @(posedge clk or negedge res) begin
      if (!res) state <= IDLE;
      else      state <= state_nx;
   end

   // Next-state and datapath next values
   always_comb begin
      state_nx   = state;
      delay_nx   = delay;
      time_nx    = time_ms;
      timeout_nx = timeout;
      case (state)
         IDLE, DONE, FOUL: begin
            if (start) begin
               state_nx   = SEED;
               time_nx    = '0;
               timeout_nx = 1'b0;
            end
         end
         SEED: state_nx = LOAD;
         LOAD: begin
            delay_nx = CNT_W'(MIN_DELAY_MS) + (CNT_W'(lfsr_val) << DELAY_SHIFT);
            state_nx = WAIT;
         end
         WAIT: begin
            if (react) begin
               state_nx = FOUL;
            end else if (tick_1ms) begin
               delay_nx = delay - CNT_W'(1);
               if (delay == CNT_W'(1)) state_nx = GO;
            end
         end
         GO: begin
            // react freezes the count, even against a same-cycle tick
            if (react) begin
               state_nx = DONE;
            end else if (tick_1ms) begin
               if (time_ms == CNT_W'(MAX_MS - 1)) begin
                  time_nx    = CNT_W'(MAX_MS);
                  timeout_nx = 1'b1;
                  state_nx   = DONE;
               end else begin
                  time_nx = time_ms + CNT_W'(1);
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Registered datapath and state-decode outputs, decoded from the next state
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         delay     <= '0;
         time_ms   <= '0;
         timeout   <= 1'b0;
         lfsr_res  <= 1'b1;
         lfsr_stop <= 1'b0;
         led       <= 1'b0;
         done      <= 1'b0;
         foul      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         delay     <= delay_nx;
         time_ms   <= time_nx;
         timeout   <= timeout_nx;
         lfsr_res  <= 1'b0;
         lfsr_stop <= (state_nx == SEED);
         led       <= (state_nx == GO);
         done      <= (state_nx == DONE);
         foul      <= (state_nx == FOUL);
         busy      <= (state_nx == SEED) || (state_nx == LOAD) ||
                      (state_nx == WAIT) || (state_nx == GO);
      end
   end

`ifdef REACTION_BEST_EN
   // Best result tracks only clean (non-timeout) entries into DONE
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         best_ms <= CNT_W'(MAX_MS);
      end else if (state == GO && state_nx == DONE && !timeout_nx && time_nx < best_ms) begin
         best_ms <= time_nx;
      end
   end
`endif

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl; define REACTION_BEST_EN to also cover best_ms.
module tb_reaction_ctrl;

   localparam int unsigned CNT_W = 14;

   logic             clk = 1'b0;
   logic             res;
   logic             start, react, tick_1ms;
   logic [7:0]       lfsr_val;
   logic             lfsr_stop, lfsr_res, led, done, foul, timeout, busy;
   logic [CNT_W-1:0] time_ms;
`ifdef REACTION_BEST_EN
   logic [CNT_W-1:0] best_ms;
`endif

   int n_chk = 0;
   int n_bad = 0;

   reaction_ctrl dut (
      .clk       (clk),
      .res       (res),
      .start     (start),
      .react     (react),
      .tick_1ms  (tick_1ms),
      .lfsr_val  (lfsr_val),
      .lfsr_stop (lfsr_stop),
      .lfsr_res  (lfsr_res),
      .led       (led),
      .time_ms   (time_ms),
      .done      (done),
      .foul      (foul),
      .timeout   (timeout),
      .busy      (busy)
`ifdef REACTION_BEST_EN
      ,
      .best_ms   (best_ms)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick_1ms = 1'b1;
         step();
      end
      tick_1ms = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic pulse_react();
      react = 1'b1;
      step();
      react = 1'b0;
   endtask

   // start, SEED, LOAD, then the random wait (lfsr_val must be set beforehand)
   task automatic to_go(input int wait_ticks);
      pulse_start();
      step();
      step();
      ticks(wait_ticks);
   endtask

   initial begin
      res = 1'b0; start = 1'b0; react = 1'b0; tick_1ms = 1'b0; lfsr_val = 8'h00;
      step();
      step();

      // reset values
      chk("rst_lfsr_res", 32'(lfsr_res), 1);
      chk("rst_lfsr_stop", 32'(lfsr_stop), 0);
      chk("rst_led", 32'(led), 0);
      chk("rst_time", 32'(time_ms), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_foul", 32'(foul), 0);
      chk("rst_timeout", 32'(timeout), 0);
      chk("rst_busy", 32'(busy), 0);
`ifdef REACTION_BEST_EN
      chk("rst_best", 32'(best_ms), 9999);
`endif
      res = 1'b1;
      chk("rel_lfsr_res_hold", 32'(lfsr_res), 1);
      step();
      chk("rel_lfsr_res_clr", 32'(lfsr_res), 0);
      chk("rel_busy", 32'(busy), 0);

      // normal round: lfsr 0x05 -> 1080 ms wait, react after 237 ms
      lfsr_val = 8'h05;
      pulse_start();
      chk("seed_stop", 32'(lfsr_stop), 1);
      chk("seed_busy", 32'(busy), 1);
      step();
      chk("load_stop", 32'(lfsr_stop), 0);
      step();
      ticks(1079);
      chk("wait_led_1079", 32'(led), 0);
      ticks(1);
      chk("go_led_1080", 32'(led), 1);
      ticks(237);
      pulse_react();
      chk("n_done", 32'(done), 1);
      chk("n_time", 32'(time_ms), 237);
      chk("n_led", 32'(led), 0);
      chk("n_timeout", 32'(timeout), 0);
      chk("n_busy", 32'(busy), 0);
      pulse_react();
      chk("n_react_ignored", 32'(time_ms), 237);

      // false start: react with a same-cycle tick at tick 500 of the wait
      pulse_start();
      chk("f_done_clr", 32'(done), 0);
      chk("f_time_clr", 32'(time_ms), 0);
      step();
      step();
      ticks(499);
      react = 1'b1; tick_1ms = 1'b1;
      step();
      react = 1'b0; tick_1ms = 1'b0;
      chk("f_foul", 32'(foul), 1);
      chk("f_led", 32'(led), 0);
      chk("f_time", 32'(time_ms), 0);
      ticks(700);
      chk("f_led_never", 32'(led), 0);

      // restart from FOUL, then run to timeout with lfsr 0 -> 1000 ms wait
      lfsr_val = 8'h00;
      pulse_start();
      chk("f_restart_foul", 32'(foul), 0);
      chk("f_restart_stop", 32'(lfsr_stop), 1);
      step();
      step();
      ticks(1000);
      chk("t_led", 32'(led), 1);
      ticks(9998);
      chk("t_time_9998", 32'(time_ms), 9998);
      chk("t_done_early", 32'(done), 0);
      ticks(1);
      chk("t_time", 32'(time_ms), 9999);
      chk("t_done", 32'(done), 1);
      chk("t_timeout", 32'(timeout), 1);
      chk("t_led_off", 32'(led), 0);
      ticks(3);
      chk("t_tick_ignored", 32'(time_ms), 9999);
      pulse_start();
      chk("t_clr_time", 32'(time_ms), 0);
      chk("t_clr_timeout", 32'(timeout), 0);
      chk("t_clr_done", 32'(done), 0);

      // ignored starts in WAIT and GO, then react+tick at count 150
      step();
      step();
      ticks(10);
      pulse_start();
      chk("i_wait_stop", 32'(lfsr_stop), 0);
      chk("i_wait_busy", 32'(busy), 1);
      ticks(990);
      chk("i_go_led", 32'(led), 1);
      ticks(50);
      pulse_start();
      chk("i_go_stop", 32'(lfsr_stop), 0);
      chk("i_go_led_hold", 32'(led), 1);
      ticks(100);
      react = 1'b1; tick_1ms = 1'b1;
      step();
      react = 1'b0; tick_1ms = 1'b0;
      chk("s_time", 32'(time_ms), 150);
      chk("s_done", 32'(done), 1);

      // start and react together in DONE: start wins
      start = 1'b1; react = 1'b1;
      step();
      start = 1'b0; react = 1'b0;
      chk("sr_stop", 32'(lfsr_stop), 1);
      chk("sr_done", 32'(done), 0);

      // reset asserted while in GO
      step();
      step();
      ticks(1005);
      chk("r_led_pre", 32'(led), 1);
      #2;
      res = 1'b0;
      #1;
      chk("r_led", 32'(led), 0);
      chk("r_lfsr_res", 32'(lfsr_res), 1);
      chk("r_time", 32'(time_ms), 0);
      chk("r_busy", 32'(busy), 0);
      step();
      res = 1'b1;
      step();

`ifdef REACTION_BEST_EN
      // best_ms across rounds 300, 250, timeout, 280
      chk("b_init", 32'(best_ms), 9999);
      to_go(1000);
      ticks(300);
      pulse_react();
      chk("b_300", 32'(best_ms), 300);
      to_go(1000);
      ticks(250);
      pulse_react();
      chk("b_250", 32'(best_ms), 250);
      to_go(1000);
      ticks(9999);
      chk("b_to_flag", 32'(timeout), 1);
      chk("b_to", 32'(best_ms), 250);
      to_go(1000);
      ticks(280);
      pulse_react();
      chk("b_280_time", 32'(time_ms), 280);
      chk("b_280", 32'(best_ms), 250);
      pulse_start();
      chk("b_start_keeps", 32'(best_ms), 250);
`else
      to_go(1000);
      ticks(42);
      pulse_react();
      chk("x_time", 32'(time_ms), 42);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
